// File: rtl/battleship_pkg.sv
// Shared types and helpers for the 5x5 battleship turn controller.
package battleship_pkg;

    localparam int BOARD_N = 5;
    localparam int CELLS   = 25;
    localparam logic [4:0] LAST_IDX = 5'(CELLS - 1);

    // Per-cell code, also consumed by the video generator board inputs.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        SHIP  = 2'd1,
        MISS  = 2'd2,
        HIT   = 2'd3
    } cell_t;

    typedef enum logic [2:0] {
        IDLE,
        PLAYER_TURN,
        PLAYER_SEARCH,
        PLAYER_CHECK,
        PC_WAIT,
        PC_SEARCH,
        PC_CHECK,
        GAME_OVER
    } state_t;

    // Linear cell index for a (row, col) pair.
    function automatic logic [4:0] cell_index(input logic [2:0] row, input logic [2:0] col);
        return ({2'b00, row} * 5'(BOARD_N)) + {2'b00, col};
    endfunction

    // Number of ships in a board mask.
    function automatic logic [4:0] popcount(input logic [CELLS-1:0] mask);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < CELLS; i++) begin
            n = n + {4'b0000, mask[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/turn_timer.sv
// Down-counter with load, enable and a single-cycle expire indication.
module turn_timer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             enable,
    input  logic [WIDTH-1:0] load_value,
    output logic [0:0]       expire
);

    logic [WIDTH-1:0] count;

    // Load wins over counting so a restart always begins from the full value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign expire = enable && (count == '0);

endmodule

// File: rtl/battleship_turn_ctrl.sv
// Turn sequencing, shot bookkeeping and win detection for player-vs-PC battleship.
module battleship_turn_ctrl
    import battleship_pkg::*;
#(
    parameter int TURN_TIMEOUT = 250_000_000,
    parameter int PC_DELAY     = 25_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [24:0] player_ships,
    input  logic [24:0] pc_ships,
    input  logic        btn_right,
    input  logic        btn_down,
    input  logic        btn_fire,
    input  logic [4:0]  rand_idx,
    output logic [49:0] board_player,
    output logic [49:0] board_pc,
    output logic [2:0]  cursor_row,
    output logic [2:0]  cursor_col,
    output logic        turn,
    output logic        game_over,
    output logic        winner
);

    localparam logic [31:0] TURN_LOAD = 32'(TURN_TIMEOUT - 1);
    localparam logic [31:0] PC_LOAD   = 32'(PC_DELAY - 1);

    state_t      state, state_next;
    cell_t       player_cells [CELLS];
    cell_t       player_cells_next [CELLS];
    cell_t       pc_cells [CELLS];
    cell_t       pc_cells_next [CELLS];
    logic [24:0] player_mask, player_mask_next;
    logic [24:0] pc_mask, pc_mask_next;
    logic [4:0]  player_ship_count, player_ship_count_next;
    logic [4:0]  pc_ship_count, pc_ship_count_next;
    logic [4:0]  player_hits, player_hits_next;
    logic [4:0]  pc_hits, pc_hits_next;
    logic [4:0]  probe, probe_next;
    logic [2:0]  cursor_row_next, cursor_col_next;
    logic        winner_next;

    logic        timer_load, timer_en;
    logic [0:0]  timer_expire;
    logic [31:0] timer_value;
    logic        player_shot, pc_shot;
    logic [4:0]  shot_idx;
    logic [4:0]  cursor_idx;

    assign cursor_idx = cell_index(cursor_row, cursor_col);
    assign timer_en   = (state == PLAYER_TURN) || (state == PC_WAIT);

    turn_timer #(.WIDTH(32)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (timer_load),
        .enable     (timer_en),
        .load_value (timer_value),
        .expire     (timer_expire)
    );

    // Next-state, board updates and counters; a shot request is resolved after the case.
    always_comb begin
        state_next             = state;
        player_cells_next      = player_cells;
        pc_cells_next          = pc_cells;
        player_mask_next       = player_mask;
        pc_mask_next           = pc_mask;
        player_ship_count_next = player_ship_count;
        pc_ship_count_next     = pc_ship_count;
        player_hits_next       = player_hits;
        pc_hits_next           = pc_hits;
        probe_next             = probe;
        cursor_row_next        = cursor_row;
        cursor_col_next        = cursor_col;
        winner_next            = winner;
        timer_load             = 1'b0;
        timer_value            = TURN_LOAD;
        player_shot            = 1'b0;
        pc_shot                = 1'b0;
        shot_idx               = '0;

        case (state)
            IDLE, GAME_OVER: begin
                if (start && (player_ships != '0) && (pc_ships != '0)) begin
                    player_mask_next       = player_ships;
                    pc_mask_next           = pc_ships;
                    for (int i = 0; i < CELLS; i++) begin
                        player_cells_next[i] = player_ships[i] ? SHIP : EMPTY;
                        pc_cells_next[i]     = EMPTY;
                    end
                    player_ship_count_next = popcount(player_ships);
                    pc_ship_count_next     = popcount(pc_ships);
                    player_hits_next       = '0;
                    pc_hits_next           = '0;
                    probe_next             = '0;
                    cursor_row_next        = '0;
                    cursor_col_next        = '0;
                    winner_next            = 1'b0;
                    state_next             = PLAYER_TURN;
                    timer_load             = 1'b1;
                    timer_value            = TURN_LOAD;
                end
            end
            PLAYER_TURN: begin
                if (btn_fire && (pc_cells[cursor_idx] == EMPTY)) begin
                    player_shot = 1'b1;
                    shot_idx    = cursor_idx;
                end else if (timer_expire[0]) begin
                    if (pc_cells[cursor_idx] == EMPTY) begin
                        player_shot = 1'b1;
                        shot_idx    = cursor_idx;
                    end else begin
                        state_next = PLAYER_SEARCH;
                        probe_next = cursor_idx;
                    end
                end else if (!btn_fire && (btn_right || btn_down)) begin
                    if (btn_right) begin
                        cursor_col_next = (cursor_col == 3'd4) ? 3'd0 : cursor_col + 3'd1;
                    end
                    if (btn_down) begin
                        cursor_row_next = (cursor_row == 3'd4) ? 3'd0 : cursor_row + 3'd1;
                    end
                    timer_load  = 1'b1;
                    timer_value = TURN_LOAD;
                end
            end
            PLAYER_SEARCH: begin
                if (probe > LAST_IDX) begin
                    probe_next = '0;
                end else if (pc_cells[probe] != EMPTY) begin
                    probe_next = (probe == LAST_IDX) ? 5'd0 : probe + 5'd1;
                end else begin
                    player_shot = 1'b1;
                    shot_idx    = probe;
                end
            end
            PLAYER_CHECK: begin
                if (player_hits == pc_ship_count) begin
                    winner_next = 1'b0;
                    state_next  = GAME_OVER;
                end else begin
                    state_next  = PC_WAIT;
                    timer_load  = 1'b1;
                    timer_value = PC_LOAD;
                end
            end
            PC_WAIT: begin
                if (timer_expire[0]) begin
                    state_next = PC_SEARCH;
                    probe_next = rand_idx;
                end
            end
            PC_SEARCH: begin
                if (probe > LAST_IDX) begin
                    probe_next = '0;
                end else if ((player_cells[probe] == MISS) || (player_cells[probe] == HIT)) begin
                    probe_next = (probe == LAST_IDX) ? 5'd0 : probe + 5'd1;
                end else begin
                    pc_shot  = 1'b1;
                    shot_idx = probe;
                end
            end
            PC_CHECK: begin
                if (pc_hits == player_ship_count) begin
                    winner_next = 1'b1;
                    state_next  = GAME_OVER;
                end else begin
                    state_next  = PLAYER_TURN;
                    timer_load  = 1'b1;
                    timer_value = TURN_LOAD;
                end
            end
            default: state_next = IDLE;
        endcase

        if (player_shot) begin
            if (pc_mask[shot_idx]) begin
                pc_cells_next[shot_idx] = HIT;
                player_hits_next        = player_hits + 5'd1;
            end else begin
                pc_cells_next[shot_idx] = MISS;
            end
            state_next = PLAYER_CHECK;
        end

        if (pc_shot) begin
            if (player_mask[shot_idx]) begin
                player_cells_next[shot_idx] = HIT;
                pc_hits_next                = pc_hits + 5'd1;
            end else begin
                player_cells_next[shot_idx] = MISS;
            end
            state_next = PC_CHECK;
        end
    end

    // State and datapath registers; reset abandons any game in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            for (int i = 0; i < CELLS; i++) begin
                player_cells[i] <= EMPTY;
                pc_cells[i]     <= EMPTY;
            end
            player_mask       <= '0;
            pc_mask           <= '0;
            player_ship_count <= '0;
            pc_ship_count     <= '0;
            player_hits       <= '0;
            pc_hits           <= '0;
            probe             <= '0;
            cursor_row        <= '0;
            cursor_col        <= '0;
            winner            <= 1'b0;
        end else begin
            state             <= state_next;
            player_cells      <= player_cells_next;
            pc_cells          <= pc_cells_next;
            player_mask       <= player_mask_next;
            pc_mask           <= pc_mask_next;
            player_ship_count <= player_ship_count_next;
            pc_ship_count     <= pc_ship_count_next;
            player_hits       <= player_hits_next;
            pc_hits           <= pc_hits_next;
            probe             <= probe_next;
            cursor_row        <= cursor_row_next;
            cursor_col        <= cursor_col_next;
            winner            <= winner_next;
        end
    end

    // Flatten the cell arrays onto the 2-bit-per-cell output buses.
    always_comb begin
        board_player = '0;
        board_pc     = '0;
        for (int i = 0; i < CELLS; i++) begin
            board_player[2*i +: 2] = player_cells[i];
            board_pc[2*i +: 2]     = pc_cells[i];
        end
    end

    assign turn      = (state == PC_WAIT) || (state == PC_SEARCH) || (state == PC_CHECK);
    assign game_over = (state == GAME_OVER);

endmodule

// File: tb/tb_battleship_turn_ctrl.sv
// Scoreboard bench for battleship_turn_ctrl with directed turn sequences.
module tb_battleship_turn_ctrl;

    localparam logic [1:0] C_EMPTY = 2'd0;
    localparam logic [1:0] C_SHIP  = 2'd1;
    localparam logic [1:0] C_MISS  = 2'd2;
    localparam logic [1:0] C_HIT   = 2'd3;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [24:0] player_ships;
    logic [24:0] pc_ships;
    logic        btn_right;
    logic        btn_down;
    logic        btn_fire;
    logic [4:0]  rand_idx;
    logic [49:0] board_player;
    logic [49:0] board_pc;
    logic [2:0]  cursor_row;
    logic [2:0]  cursor_col;
    logic        turn;
    logic        game_over;
    logic        winner;

    typedef struct {
        string       name;
        int          cyc;
        logic [49:0] bp;
        logic [49:0] bc;
        logic [2:0]  row;
        logic [2:0]  col;
        logic        turn;
        logic        go;
        logic        win;
        logic        chk_win;
    } exp_t;

    exp_t sb[$];
    int   cyc;
    int   checks;
    int   errors;

    logic [49:0] exp_bp;
    logic [49:0] exp_bc;
    logic [2:0]  exp_row;
    logic [2:0]  exp_col;
    logic        exp_turn;
    logic        exp_go;
    logic        exp_win;

    battleship_turn_ctrl #(
        .TURN_TIMEOUT (8),
        .PC_DELAY     (3)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .player_ships (player_ships),
        .pc_ships     (pc_ships),
        .btn_right    (btn_right),
        .btn_down     (btn_down),
        .btn_fire     (btn_fire),
        .rand_idx     (rand_idx),
        .board_player (board_player),
        .board_pc     (board_pc),
        .cursor_row   (cursor_row),
        .cursor_col   (cursor_col),
        .turn         (turn),
        .game_over    (game_over),
        .winner       (winner)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Counts rising edges; expectations are tagged with the edge count they describe.
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops every expectation due for this cycle and compares it with the outputs.
    always @(negedge clk) begin
        exp_t e;
        #1;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            checks = checks + 1;
            if (e.cyc < cyc) begin
                errors = errors + 1;
                $display("[TB] FAIL %s: expectation for cycle %0d reached monitor at cycle %0d", e.name, e.cyc, cyc);
            end else if (!((board_player === e.bp) && (board_pc === e.bc) &&
                           (cursor_row === e.row) && (cursor_col === e.col) &&
                           (turn === e.turn) && (game_over === e.go) &&
                           (!e.chk_win || (winner === e.win)))) begin
                errors = errors + 1;
                $display("[TB] FAIL %s: got bp=%h bc=%h row=%0d col=%0d turn=%b go=%b win=%b, expected bp=%h bc=%h row=%0d col=%0d turn=%b go=%b win=%b(chk=%b)",
                         e.name, board_player, board_pc, cursor_row, cursor_col, turn, game_over, winner,
                         e.bp, e.bc, e.row, e.col, e.turn, e.go, e.win, e.chk_win);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [49:0] setCell(input logic [49:0] b, input int i, input logic [1:0] c);
        logic [49:0] r;
        r = b;
        r[2*i +: 2] = c;
        return r;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic r, input logic d, input logic f);
        btn_right = r;
        btn_down  = d;
        btn_fire  = f;
        @(negedge clk);
        btn_right = 1'b0;
        btn_down  = 1'b0;
        btn_fire  = 1'b0;
    endtask

    task automatic startGame(input logic [24:0] pm, input logic [24:0] cm);
        player_ships = pm;
        pc_ships     = cm;
        start        = 1'b1;
        @(negedge clk);
        start        = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic chk_win);
        exp_t e;
        e.name    = name;
        e.cyc     = cyc;
        e.bp      = exp_bp;
        e.bc      = exp_bc;
        e.row     = exp_row;
        e.col     = exp_col;
        e.turn    = exp_turn;
        e.go      = exp_go;
        e.win     = exp_win;
        e.chk_win = chk_win;
        sb.push_back(e);
    endtask

    task automatic clearModel();
        exp_bp   = '0;
        exp_bc   = '0;
        exp_row  = '0;
        exp_col  = '0;
        exp_turn = 1'b0;
        exp_go   = 1'b0;
        exp_win  = 1'b0;
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst_n        = 1'b0;
        start        = 1'b0;
        player_ships = '0;
        pc_ships     = '0;
        btn_right    = 1'b0;
        btn_down     = 1'b0;
        btn_fire     = 1'b0;
        rand_idx     = '0;
        clearModel();

        tick(2);
        checkOutput("reset_values", 1'b1);
        tick(1);
        rst_n = 1'b1;
        tick(1);
        checkOutput("idle_after_release", 1'b1);

        // Player sinks the single PC ship on the first shot.
        startGame(25'h1, 25'h2);
        exp_bp = setCell('0, 0, C_SHIP);
        checkOutput("a_start_loads_boards", 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        exp_col = 3'd1;
        checkOutput("a_move_right", 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        exp_bc = setCell(exp_bc, 1, C_HIT);
        checkOutput("a_fire_hit_cell1", 1'b0);
        tick(1);
        exp_go  = 1'b1;
        exp_win = 1'b0;
        checkOutput("a_player_wins", 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("a_buttons_ignored_game_over", 1'b1);
        startGame(25'h0, 25'h2);
        checkOutput("a_start_zero_mask_ignored", 1'b1);

        // Player misses, PC waits three cycles then sinks the player's ship.
        startGame(25'h1, 25'h2);
        clearModel();
        exp_bp = setCell('0, 0, C_SHIP);
        checkOutput("b_start", 1'b0);
        rand_idx = 5'd0;
        applyStimulus(1'b0, 1'b0, 1'b1);
        exp_bc = setCell(exp_bc, 0, C_MISS);
        checkOutput("b_fire_miss_cell0", 1'b0);
        tick(1);
        exp_turn = 1'b1;
        checkOutput("b_pc_wait_cycle1", 1'b0);
        tick(1);
        checkOutput("b_pc_wait_cycle2", 1'b0);
        tick(1);
        checkOutput("b_pc_wait_cycle3", 1'b0);
        tick(1);
        checkOutput("b_pc_search", 1'b0);
        tick(1);
        exp_bp = setCell(exp_bp, 0, C_HIT);
        checkOutput("b_pc_hit_cell0", 1'b0);
        tick(1);
        exp_turn = 1'b0;
        exp_go   = 1'b1;
        exp_win  = 1'b1;
        checkOutput("b_pc_wins", 1'b1);

        // Longer game: ignored fires, timeout search, PC probe skipping and wrap.
        startGame(25'h1000000, 25'h1FFFFFE);
        clearModel();
        exp_bp = setCell('0, 24, C_SHIP);
        checkOutput("c_start", 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        exp_bc = setCell(exp_bc, 0, C_MISS);
        checkOutput("c_fire_cell0_miss", 1'b0);
        tick(1);
        exp_turn = 1'b1;
        checkOutput("c_pc_wait", 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("c_fire_during_pc_ignored", 1'b0);
        tick(3);
        exp_bp = setCell(exp_bp, 0, C_MISS);
        checkOutput("c_pc_miss_cell0", 1'b0);
        tick(1);
        exp_turn = 1'b0;
        checkOutput("c_back_to_player", 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("c_refire_same_cell_ignored", 1'b0);
        tick(6);
        checkOutput("c_no_early_timeout", 1'b0);
        tick(1);
        checkOutput("c_search_probe_cell0", 1'b0);
        tick(1);
        checkOutput("c_search_probe_cell1", 1'b0);
        tick(1);
        exp_bc = setCell(exp_bc, 1, C_HIT);
        checkOutput("c_auto_fire_cell1", 1'b0);
        tick(5);
        exp_turn = 1'b1;
        checkOutput("c_pc_probe_pending", 1'b0);
        tick(1);
        exp_bp = setCell(exp_bp, 1, C_MISS);
        checkOutput("c_pc_skips_cell0", 1'b0);
        tick(1);
        exp_turn = 1'b0;
        checkOutput("c_player_turn_again", 1'b0);

        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        exp_col = 3'd2;
        checkOutput("c_cursor_col2", 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        exp_bc = setCell(exp_bc, 2, C_HIT);
        checkOutput("c_fire_cell2_hit", 1'b0);
        tick(7);
        exp_turn = 1'b1;
        exp_bp   = setCell(exp_bp, 2, C_MISS);
        checkOutput("c_pc_shot_cell2", 1'b0);
        tick(1);
        exp_turn = 1'b0;

        applyStimulus(1'b1, 1'b0, 1'b0);
        exp_col = 3'd3;
        applyStimulus(1'b0, 1'b0, 1'b1);
        exp_bc = setCell(exp_bc, 3, C_HIT);
        checkOutput("c_fire_cell3_hit", 1'b0);
        tick(8);
        exp_turn = 1'b1;
        exp_bp   = setCell(exp_bp, 3, C_MISS);
        checkOutput("c_pc_shot_cell3", 1'b0);
        tick(1);
        exp_turn = 1'b0;

        applyStimulus(1'b1, 1'b0, 1'b0);
        exp_col  = 3'd4;
        rand_idx = 5'd27;
        applyStimulus(1'b0, 1'b0, 1'b1);
        exp_bc = setCell(exp_bc, 4, C_HIT);
        checkOutput("c_fire_cell4_hit", 1'b0);
        tick(9);
        exp_turn = 1'b1;
        checkOutput("c_probe_wrap_pending", 1'b0);
        tick(1);
        exp_bp = setCell(exp_bp, 4, C_MISS);
        checkOutput("c_pc_shot_cell4_after_wrap", 1'b0);
        tick(1);
        exp_turn = 1'b0;

        applyStimulus(1'b1, 1'b1, 1'b0);
        exp_col = 3'd0;
        exp_row = 3'd1;
        checkOutput("c_wrap_col_and_row_down", 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        exp_bc = setCell(exp_bc, 5, C_HIT);
        checkOutput("c_fire_cell5_hit", 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        clearModel();
        checkOutput("c_async_reset_mid_pc_wait", 1'b1);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        checkOutput("d_idle_after_reset", 1'b1);

        // First game after reset loads cleanly; row wraps after five downs.
        startGame(25'h1, 25'h2);
        exp_bp = setCell('0, 0, C_SHIP);
        checkOutput("d_first_start_after_reset", 1'b0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0);
        end
        exp_row = 3'd4;
        checkOutput("d_row4", 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        exp_row = 3'd0;
        checkOutput("d_row_wrap", 1'b0);

        tick(3);
        if (sb.size() != 0) begin
            $display("[TB] FAIL scoreboard_drain: %0d expectations never compared, required 0", sb.size());
            checks = checks + sb.size();
            errors = errors + sb.size();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/battleship_turn_ctrl.md
BATTLESHIP_TURN_CTRL -- requirements
Module: battleship_turn_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk (rising edge) and rst_n (asserted 0, asynchronous assert).
REQ-002 Parameters SHALL be, one per line:
- TURN_TIMEOUT, 250_000_000, player-turn timeout in clk cycles (>=2).
- PC_DELAY, 25_000_000, PC think time in clk cycles (>=1).
REQ-003 Ports SHALL be, one per line:
- clk  in  1  system clock.
- rst_n  in  1  async active-low reset.
- start  in  1  single-cycle pulse, new game.
- player_ships  in  25  player ship mask, bit i = cell row*5+col.
- pc_ships  in  25  PC ship mask, same indexing.
- btn_right  in  1  pulse, cursor column +1.
- btn_down  in  1  pulse, cursor row +1.
- btn_fire  in  1  pulse, player fires at cursor.
- rand_idx  in  5  free-running random cell index from an external LFSR.
- board_player  out  50  2-bit code per cell of the player board (PC shots), cell i at bits [2i+1:2i].
- board_pc  out  50  2-bit code per cell of the PC board (player shots).
- cursor_row  out  3  0..4.
- cursor_col  out  3  0..4.
- turn  out  1  0 = player, 1 = PC.
- game_over  out  1  game finished.
- winner  out  1  0 = player, 1 = PC; valid while game_over = 1.

Function
REQ-004 Cell codes SHALL be: 0 EMPTY, 1 SHIP (unshot ship, player board only), 2 MISS, 3 HIT.
REQ-005 States SHALL be: IDLE, PLAYER_TURN, PLAYER_SEARCH, PLAYER_CHECK, PC_WAIT, PC_SEARCH, PC_CHECK, GAME_OVER.
REQ-006 In IDLE or GAME_OVER, start = 1 with both masks nonzero SHALL do all of the following, then enter PLAYER_TURN:
- latch both masks;
- load board_player with SHIP/EMPTY per mask;
- set board_pc all EMPTY;
- store ship counts by popcount;
- clear hit counters, cursor and game_over.
REQ-007 start in any other state, or with either mask zero, SHALL be ignored.
REQ-008 In PLAYER_TURN, btn_right SHALL advance cursor_col by one, wrapping 4->0. btn_down SHALL advance cursor_row by one, wrapping 4->0. Either move SHALL reload the turn timer.
REQ-009 btn_fire SHALL have priority over moves in the same cycle; the moves in that cycle SHALL be discarded.
REQ-010 btn_fire on an unshot cursor cell SHALL, at that edge, write HIT (pc_ships bit set, player hit count +1) or MISS to board_pc, then enter PLAYER_CHECK.
REQ-011 btn_fire on an already-shot cell SHALL be ignored, with no state change.
REQ-012 The turn timer SHALL load TURN_TIMEOUT-1 on entry to PLAYER_TURN.
REQ-013 On turn-timer expiry, the player SHALL auto-fire at the cursor cell if it is unshot. Otherwise the block SHALL enter PLAYER_SEARCH with the probe index set to the cursor index.
REQ-014 Search (PLAYER_SEARCH and PC_SEARCH) SHALL examine one probe per cycle:
- index >= 25 -> index becomes 0;
- shot cell -> index +1, wrapping 24->0;
- unshot cell -> fire there and go to the matching CHECK state.
REQ-015 PLAYER_CHECK SHALL enter GAME_OVER with winner = 0 if the player hit count equals the PC ship count, else enter PC_WAIT.
REQ-016 turn SHALL be 1 in PC_WAIT, PC_SEARCH and PC_CHECK, and 0 otherwise.
REQ-017 PC_WAIT SHALL last exactly PC_DELAY cycles, then enter PC_SEARCH with the probe index set to rand_idx sampled at that edge.
REQ-018 A PC shot SHALL write HIT (SHIP cell, PC hit count +1) or MISS (EMPTY cell) to board_player.
REQ-019 PC_CHECK SHALL enter GAME_OVER with winner = 1 on PC hits equal to player ships, else enter PLAYER_TURN.
REQ-020 Each search SHALL terminate within 26 cycles; an unshot cell always exists while the game is not over.
REQ-021 In GAME_OVER, game_over = 1 and the boards SHALL be frozen. All buttons SHALL be ignored outside PLAYER_TURN.
REQ-022 Hit counters and ship counts SHALL be 5 bits wide (maximum 25).

Reset
REQ-023 rst_n = 0 SHALL immediately set:
- state IDLE;
- both boards all EMPTY (0);
- cursor 0,0;
- turn 0, game_over 0, winner 0;
- all counters, the probe index and the latched masks to 0.
REQ-024 Reset in the middle of a game SHALL abandon the game with no residual state. The first start after reset release SHALL behave as in REQ-006.

Structure
REQ-025 The shared package battleship_pkg SHALL hold:
- the cell_t enum (EMPTY, SHIP, MISS, HIT);
- the state enum;
- BOARD_N = 5 and CELLS = 25;
- the cell-index function (row*5+col).
The videoGen board inputs SHALL use the same cell_t encoding.
REQ-026 A single sub-module, turn_timer, SHALL be used: a down-counter with load, enable and expire pulse. One instance SHALL serve both TURN_TIMEOUT and PC_DELAY.

Verification (TURN_TIMEOUT = 8, PC_DELAY = 3)
REQ-027 Start with player_ships = 0x1, pc_ships = 0x2; btn_right, then btn_fire -> board_pc cell 1 = HIT; one cycle later game_over = 1, winner = 0, turn never goes to 1.
REQ-028 Fire at cell 0 (MISS); hold rand_idx = 0 -> PC_WAIT lasts 3 cycles; board_player cell 0 = HIT; game_over = 1, winner = 1.
REQ-029 Fire twice at the same cell, with a second fire during the PC turn -> the second fire is ignored and board_pc is unchanged.
REQ-030 Idle for 8 cycles in PLAYER_TURN with cell 0 already shot -> PLAYER_SEARCH probes cell 0, then shoots cell 1 (2 cycles).
REQ-031 rand_idx = 27 with player cells 0..3 already shot -> the probe goes 27 -> 0 -> 1 -> 2 -> 3 -> 4, and cell 4 is shot.
REQ-032 Cursor at col 4: btn_right and btn_down pulsed together -> col = 0, row = 1; assert rst_n = 0 mid-PC_WAIT -> all outputs return to reset values at once.
